pcx_data_pipe: RTL



---
 rtl/pcx_data_pipe.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pcx_data_pipe.sv
// PCX request retiming pipe: STAGES unstalled registers feeding a skid FIFO, with a
// registered occupancy-derived stall to the source. Parity carry/check: PCX_DATA_PIPE_PARITY_EN.
module pcx_data_pipe #(
    parameter int unsigned WIDTH      = 124,
    parameter int unsigned STAGES     = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             rclk,
    input  logic             arst_l,
    input  logic [WIDTH-1:0] pcx_data_px_l,
    input  logic             pcx_par_px,
    input  logic             pcx_data_rdy_px,
    output logic             pcx_stall_px2,
    output logic [WIDTH-1:0] pcx_data_out,
    output logic             pcx_data_rdy_out,
    input  logic             pcx_stall_in,
    output logic             pcx_ovfl_err,
    output logic             pcx_par_err
);

`ifdef PCX_DATA_PIPE_PARITY_EN
    localparam int unsigned EW = WIDTH + 1;
`else
    localparam int unsigned EW = WIDTH;
`endif
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned RES_W = $clog2(FIFO_DEPTH + STAGES + 1);

    logic [STAGES-1:0] stg_vld_q, stg_vld_d;
    logic [EW-1:0]     stg_dat_q [STAGES];
    logic [EW-1:0]     stg_dat_d [STAGES];
    logic [EW-1:0]     mem_q [FIFO_DEPTH];
    logic [EW-1:0]     mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic              rdy_q, rdy_d;
    logic              stall_q, stall_d;
    logic              ovfl_q, ovfl_d;
    logic [EW-1:0]     entry_in;
    logic [EW-1:0]     head;
    logic              accept, push, pop, full, wr_en;
    logic [RES_W-1:0]  reserved;

    // Stage-1 entry: true-polarity data, with the source parity bit on top when enabled.
`ifdef PCX_DATA_PIPE_PARITY_EN
    assign entry_in = {pcx_par_px, ~pcx_data_px_l};
`else
    logic unused_par;
    assign unused_par = pcx_par_px;
    assign entry_in   = ~pcx_data_px_l;
`endif

    // Pipe shift, FIFO push/pop, stall accounting and output register next-state.
    always_comb begin
        accept   = pcx_data_rdy_px & ~stall_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;

        stg_vld_d[0] = accept;
        stg_dat_d[0] = entry_in;
        for (int unsigned i = 1; i < STAGES; i++) begin
            stg_vld_d[i] = stg_vld_q[i-1];
            stg_dat_d[i] = stg_dat_q[i-1];
        end

        head  = mem_q[rd_ptr_q];
        full  = (occ_q == OCC_W'(FIFO_DEPTH));
        push  = stg_vld_q[STAGES-1];
        pop   = (occ_q != '0) & ~pcx_stall_in;
        wr_en = push & (~full | pop);

        if (wr_en) begin
            mem_d[wr_ptr_q] = stg_dat_q[STAGES-1];
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (wr_en & ~pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (pop & ~wr_en) begin
            occ_d = occ_q - OCC_W'(1);
        end

        // Everything accepted but not yet popped holds a FIFO slot.
        reserved = RES_W'(occ_d);
        for (int unsigned i = 0; i < STAGES; i++) begin
            reserved = reserved + RES_W'(stg_vld_d[i]);
        end
        stall_d = (reserved >= RES_W'(FIFO_DEPTH));

        rdy_d  = pop;
        dout_d = pop ? head[WIDTH-1:0] : dout_q;
        ovfl_d = ovfl_q | (pcx_data_rdy_px & stall_q) | (push & ~wr_en);
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            stg_vld_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            dout_q    <= '0;
            rdy_q     <= 1'b0;
            stall_q   <= 1'b0;
            ovfl_q    <= 1'b0;
        end else begin
            stg_vld_q <= stg_vld_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            dout_q    <= dout_d;
            rdy_q     <= rdy_d;
            stall_q   <= stall_d;
            ovfl_q    <= ovfl_d;
        end
    end

    // Datapath storage is qualified by valid bits and occupancy, so it carries no reset.
    always_ff @(posedge rclk) begin
        stg_dat_q <= stg_dat_d;
        mem_q     <= mem_d;
    end

`ifdef PCX_DATA_PIPE_PARITY_EN
    logic par_err_q, par_err_d;

    always_comb begin
        par_err_d = par_err_q | (pop & ((^head[WIDTH-1:0]) != head[WIDTH]));
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign pcx_par_err = par_err_q;
`else
    assign pcx_par_err = 1'b0;
`endif

    assign pcx_stall_px2    = stall_q;
    assign pcx_data_out     = dout_q;
    assign pcx_data_rdy_out = rdy_q;
    assign pcx_ovfl_err     = ovfl_q;

endmodule
